mult_seq_control: RTL and testbench

MULT_SEQ_CONTROL -- requirements
Module: mult_seq_control

---
 rtl/mult_seq_control.sv | 120 ++++++++++++
 tb/tb_mult_seq_control.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_control.sv
// rtl/mult_seq_control.sv - sequencer for an 8-bit add/shift signed multiplier datapath
// Optional MULT_CTRL_SYNC_EN: passes Run and ClearA_LoadB through 2-flop synchronizers.
module mult_seq_control (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       ClearA_LoadB,
    input  logic       M,
    output logic       Clr_Ld,
    output logic       ClearAX,
    output logic       Add,
    output logic       Sub,
    output logic       Shift,
    output logic       Busy,
    output logic       Done,
    output logic [2:0] Step
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLRAX = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] step_q, step_d;
    logic       rst_q;
    logic       run_s;
    logic       ld_s;

`ifdef MULT_CTRL_SYNC_EN
    logic [1:0] run_sync_q;
    logic [1:0] ld_sync_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            run_sync_q <= 2'b00;
            ld_sync_q  <= 2'b00;
        end else begin
            run_sync_q <= {run_sync_q[0], Run};
            ld_sync_q  <= {ld_sync_q[0], ClearA_LoadB};
        end
    end

    assign run_s = run_sync_q[1];
    assign ld_s  = ld_sync_q[1];
`else
    assign run_s = Run;
    assign ld_s  = ClearA_LoadB;
`endif

    // rst_q marks the first cycle after a reset edge so every output stays quiet then
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            step_q  <= 3'd0;
            rst_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            rst_q   <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        Clr_Ld  = 1'b0;
        ClearAX = 1'b0;
        Add     = 1'b0;
        Sub     = 1'b0;
        Shift   = 1'b0;
        Busy    = 1'b0;
        Done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                Clr_Ld = ld_s & ~run_s & ~rst_q;
                if (run_s) begin
                    state_d = S_CLRAX;
                    step_d  = 3'd0;
                end
            end
            S_CLRAX: begin
                ClearAX = 1'b1;
                Busy    = 1'b1;
                step_d  = 3'd0;
                state_d = S_ADD;
            end
            S_ADD: begin
                Busy = 1'b1;
                // the last multiplier bit carries negative weight, so it subtracts
                if (M) begin
                    if (step_q == 3'd7) Sub = 1'b1;
                    else                Add = 1'b1;
                end
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                Shift = 1'b1;
                Busy  = 1'b1;
                if (step_q == 3'd7) begin
                    state_d = S_HOLD;
                end else begin
                    step_d  = step_q + 3'd1;
                    state_d = S_ADD;
                end
            end
            S_HOLD: begin
                Done = 1'b1;
                if (!run_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign Step = step_q;

endmodule

// File: tb/tb_mult_seq_control.sv
// tb/tb_mult_seq_control.sv - directed and scoreboard bench for mult_seq_control
module tb_mult_seq_control;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Run = 1'b0;
    logic       ClearA_LoadB = 1'b0;
    logic       M;
    logic       Clr_Ld, ClearAX, Add, Sub, Shift, Busy, Done;
    logic [2:0] Step;

    logic       use_dp = 1'b0;
    logic       m_drv = 1'b0;
    logic [7:0] dp_s = 8'h00;
    logic       dp_x = 1'b0;
    logic [7:0] dp_a = 8'h00;
    logic [7:0] dp_b = 8'h00;

    int total = 0;
    int bad = 0;
    int idle_step = 0;
    logic [16:0] exp_q[$];

    always #5 Clk = ~Clk;

    assign M = use_dp ? dp_b[0] : m_drv;

    mult_seq_control dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
        .Clr_Ld(Clr_Ld), .ClearAX(ClearAX), .Add(Add), .Sub(Sub), .Shift(Shift),
        .Busy(Busy), .Done(Done), .Step(Step)
    );

    // Behavioural 8-bit datapath: X:A:B with X as sign extension of A
    always @(posedge Clk) begin
        logic [8:0] sum;
        if (Clr_Ld) begin
            dp_b <= dp_s; dp_a <= 8'h00; dp_x <= 1'b0;
        end else if (ClearAX) begin
            dp_a <= 8'h00; dp_x <= 1'b0;
        end else if (Add) begin
            sum = {dp_a[7], dp_a} + {dp_s[7], dp_s};
            dp_a <= sum[7:0]; dp_x <= sum[8];
        end else if (Sub) begin
            sum = {dp_a[7], dp_a} - {dp_s[7], dp_s};
            dp_a <= sum[7:0]; dp_x <= sum[8];
        end else if (Shift) begin
            dp_a <= {dp_x, dp_a[7:1]};
            dp_b <= {dp_a[0], dp_b[7:1]};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [9:0] pack_out();
        return {Clr_Ld, ClearAX, Add, Sub, Shift, Busy, Done, Step};
    endfunction

    // Expected {Clr_Ld,ClearAX,Add,Sub,Shift,Busy,Done,Step} c cycles after Run sampled in IDLE
    function automatic logic [9:0] exp_out(input int c, input logic m, input int off, input int st0);
        logic [6:0] s;
        int stp;
        s = 7'b0; stp = 7;
        if (c == 0) begin
            stp = st0;
        end else if (c == 1) begin
            s = 7'b0100010; stp = 0;
        end else if (c <= 17 && (c % 2) == 0) begin
            s[1] = 1'b1; stp = (c - 2) / 2;
            s[4] = m && (c < 16);
            s[3] = m && (c == 16);
        end else if (c <= 17) begin
            s = 7'b0000110; stp = (c - 3) / 2;
        end else if (c <= off) begin
            s = 7'b0000001;
        end
        return {s, 3'(stp)};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Run raised at c=0; Run dropped at cycle off (>=18); noisy toggles Run/ClearA_LoadB while busy
    task automatic run_seq(input logic m, input int off, input bit noisy, input string tag);
        m_drv = m;
        for (int c = 0; c <= off + 1; c++) begin
            if (c == 0) begin
                Run = 1'b1; ClearA_LoadB = 1'b1;
            end else if (c <= 17) begin
                Run = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
                ClearA_LoadB = noisy ? 1'b1 : 1'b0;
            end else begin
                Run = (c < off); ClearA_LoadB = 1'b0;
            end
            #1;
            chk($sformatf("%s_c%0d", tag, c), 32'(pack_out()), 32'(exp_out(c, m, off, idle_step)));
            tick();
        end
        idle_step = 7;
    endtask

    task automatic dp_mult(input logic [7:0] bval, input logic [7:0] sval, input string tag);
        logic signed [7:0]  bs, ss;
        logic signed [15:0] p;
        logic [16:0]        got, want;
        int                 n;
        use_dp = 1'b1;
        dp_s = bval; ClearA_LoadB = 1'b1;
        tick();
        ClearA_LoadB = 1'b0; dp_s = sval; Run = 1'b1;
        bs = bval; ss = sval; p = bs * ss;
        exp_q.push_back({p[15], p});
        n = 0;
        while (!Done && n < 40) begin
            tick(); n++;
        end
        chk({tag, "_done"}, 32'(Done), 32'd1);
        want = exp_q.pop_front();
        got = {dp_x, dp_a, dp_b};
        chk({tag, "_xab"}, 32'(got), 32'(want));
        Run = 1'b0;
        tick(); tick();
        idle_step = 7;
        use_dp = 1'b0;
    endtask

    initial begin
        tick(); tick();
        Reset = 1'b0;
        #1;
        chk("reset_out", 32'(pack_out()), 32'd0);
        tick();
        chk("idle_quiet", 32'(pack_out()), 32'd0);

        ClearA_LoadB = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("clrld_%0d", i), 32'(pack_out()), 32'({7'b1000000, 3'd0}));
            tick();
        end
        ClearA_LoadB = 1'b0;
        #1;
        chk("clrld_off", 32'(pack_out()), 32'd0);
        tick();

        run_seq(1'b1, 22, 1'b0, "m1_hold");
        run_seq(1'b0, 18, 1'b1, "m0_pulse");
        run_seq(1'b1, 18, 1'b1, "m1_noisy");

        m_drv = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            Run = (c == 0); ClearA_LoadB = (c != 0);
            #1;
            chk($sformatf("abort_c%0d", c), 32'(pack_out()), 32'(exp_out(c, 1'b1, 18, idle_step)));
            if (c < 10) tick();
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        #1;
        chk("abort_after", 32'(pack_out()), 32'd0);
        tick();
        chk("abort_idle_ld", 32'(pack_out()), 32'({7'b1000000, 3'd0}));
        ClearA_LoadB = 1'b0;
        idle_step = 0;
        tick();

        dp_mult(8'hC5, 8'h07, "dp_c5x07");
        dp_mult(8'h04, 8'h03, "dp_04x03");
        for (int i = 0; i < 4; i++)
            dp_mult(8'($urandom), 8'($urandom), $sformatf("dp_rand%0d", i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
